pie_tx_encoder: RTL and testbench
=================================

// Module: pie_tx_encoder
// PURPOSE
//  Reader-to-tag transmit encoder for the RFID link. Takes a command bitstream and a frame type.
//  Produces the PIE baseband envelope (tx_env) that drives the carrier modulator.
//  Envelope sequence: delimiter, data-0, RTcal, optional TRcal, PIE data symbols, then continuous wave.
//  This is the downlink counterpart of the uplink preamble detection/decode path.
// PARAMETERS
//  TARI_TICKS   4    data-0 symbol length, in tick periods
//  DATA1_TICKS  6    data-1 symbol length, in ticks; must satisfy 1.5*TARI <= DATA1 <= 2*TARI
//  PW_TICKS     2    low pulse width ending every symbol; must satisfy 0 < PW < TARI
//  DELIM_TICKS  3    delimiter low duration, in ticks
//  TRCAL_TICKS  16   TRcal symbol length, in ticks
//  LEN_W        9    width of nbits
//  localparam RTCAL_TICKS = TARI_TICKS + DATA1_TICKS
//  localparam CNT_W = $clog2(max(all lengths) + 1)
// PORTS
//  clk         in   1      single clock
//  rst_n       in   1      asynchronous, active-low reset
//  tick        in   1      sample strobe; all durations are counted in tick cycles
//  start       in   1      frame request; sampled only in IDLE
//  with_trcal  in   1      1 = preamble (includes TRcal), 0 = frame-sync; captured at start
//  nbits       in   LEN_W  number of command bits; captured at start
//  in_dat      in   1      next command bit, MSB first
//  in_vld      in   1      in_dat is valid
//  in_rdy      out  1      bit consumed this cycle; a pop occurs when in_rdy && in_vld
//  tx_env      out  1      envelope: 1 = carrier on, 0 = attenuated
//  busy        out  1      frame in progress (state != IDLE)
//  done        out  1      one-cycle pulse when a frame completes normally
//  underrun    out  1      one-cycle pulse when a bit was needed but in_vld = 0
// BEHAVIOUR
//  - Reset values: tx_env = 1, busy = 0, done = 0, underrun = 0, in_rdy = 0, state = IDLE, counters = 0.
//  - Reset may assert mid-frame. Its effect is immediate: tx_env goes to 1 and the frame is discarded.
//  - States: IDLE, DELIM, DATA0, RTCAL, TRCAL, BITS.
//  - IDLE
//    - If start = 1: latch with_trcal and nbits, go to DELIM, tx_env <= 0 on the same edge.
//    - start does not wait for tick.
//  - Counter advances only on tick cycles. Each state lasts exactly its length in ticks.
//    - DELIM: tx_env = 0 for DELIM_TICKS ticks.
//    - Symbol of length L: tx_env = 1 for the first L-PW ticks, then 0 for the last PW ticks.
//    - tx_env is registered and updates on the tick edge.
//  - Transitions on the last tick of each state:
//    - DELIM -> DATA0 -> RTCAL
//    - RTCAL -> TRCAL if with_trcal = 1, otherwise RTCAL -> BITS
//    - TRCAL -> BITS
//  - BITS, start of each symbol (tick cycle at symbol boundary)
//    - in_rdy = 1 combinationally on that cycle only.
//    - If in_vld = 1: pop in_dat and set L = TARI (bit 0) or DATA1 (bit 1). Remaining count decrements.
//    - If in_vld = 0: pulse underrun, go to IDLE, tx_env <= 1. No done pulse.
//  - Completion
//    - After the last tick of the final symbol: tx_env <= 1, pulse done on the same edge, go to IDLE.
//    - nbits = 0: no bits are requested. Go to IDLE with done after RTCAL, or after TRCAL if selected.
//  - start while busy is ignored; with_trcal and nbits stay at their latched values.
//  - Back-to-back frames: start may be high on the cycle after done. That DELIM begins with no CW gap.
//    Upstream enforces any required CW gap.
//  - tick = 0 for any number of cycles freezes all counters and outputs (except done/underrun pulses).
//  - Arithmetic: symbol counter is CNT_W bits and counts down from L-1 with no wrap. Bit counter is LEN_W bits.
// STRUCTURE
//  - rfid_tx_pkg holds the state encoding and the default tick constants for TARI/PW/DELIM/TRCAL.
//    The same package holds the 2'b/3'b state widths.
//  - One sub-module, pie_symbol_timer, contains the counter and the high/low compare.
//    - Inputs: tick, load, length, pw.
//    - Outputs: env, last.
//  - FSM, bit counter and handshake live in pie_tx_encoder.
// TESTING (all scenarios use defaults and tick = 1 every cycle unless stated)
//  1. Frame-sync, nbits=2, bits 1,0 -> tx_env = 000 1100 1111111100 111100 1100, then 1.
//     Two pops; done after tick 27.
//  2. Preamble, nbits=1, bit 0 -> as scenario 1 up to RTcal, then TRcal = 14x1 + 2x0, then 1100.
//     done after tick 37.
//  3. tick asserted every 3rd cycle, scenario 1 stimulus -> identical tick-sampled waveform.
//     done after 81 cycles.
//  4. nbits=3, in_vld deasserted before bit 2 -> two pops, then underrun pulse at the 3rd boundary.
//     tx_env=1, busy=0, done never asserts.
//  5. rst_n low mid-RTCAL -> tx_env=1 and busy=0 immediately.
//     A new start after release gives a clean delimiter.
//  6. start pulsed while busy, with nbits changed -> ignored; frame length matches the original nbits.
//     nbits=0 frame-sync -> done after tick 17.

Source files
------------

// File: rtl/rfid_tx_pkg.sv
// PIE downlink encoder shared types and default timing.
// Durations are expressed in tick periods.
package rfid_tx_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    DELIM,
    DATA0,
    RTCAL,
    TRCAL,
    BITS
  } state_t;

  localparam int TARI_DEF  = 4;
  localparam int DATA1_DEF = 6;
  localparam int PW_DEF    = 2;
  localparam int DELIM_DEF = 3;
  localparam int TRCAL_DEF = 16;

  function automatic int max5(
    input int a,
    input int b,
    input int c,
    input int d,
    input int e
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/pie_tx_encoder_if.sv
// Command bit stream handshake into the PIE encoder.
// A bit is consumed when in_rdy and in_vld are both high.
interface pie_tx_encoder_if;

  logic in_dat;
  logic in_vld;
  logic in_rdy;

  modport master (
    output in_dat,
    output in_vld,
    input  in_rdy
  );

  modport slave (
    input  in_dat,
    input  in_vld,
    output in_rdy
  );

endinterface

// File: rtl/pie_symbol_timer.sv
// Down-counter for one PIE symbol with the high/low compare.
// env is high while the count is at or above the pulse width.
module pie_symbol_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] length,
  input  logic [CNT_W-1:0] pw,
  output logic             env,
  output logic             last
);

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t cnt_q;
  cnt_t pw_q;
  cnt_t dec;
  cnt_t len_m1;

  assign dec    = (cnt_q == '0) ? '0
                : cnt_q - cnt_t'(1);
  assign len_m1 = length - cnt_t'(1);
  assign last   = (cnt_q == '0);

  // load ignores tick so a frame can start on any cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pw_q  <= '0;
      env   <= 1'b1;
    end else if (load) begin
      cnt_q <= len_m1;
      pw_q  <= pw;
      env   <= (len_m1 >= pw);
    end else if (tick) begin
      cnt_q <= dec;
      env   <= (dec >= pw_q);
    end
  end

endmodule

// File: rtl/pie_tx_encoder.sv
// Reader-to-tag PIE envelope generator: delimiter,
// data-0, RTcal, optional TRcal, data symbols, then CW.
module pie_tx_encoder
  import rfid_tx_pkg::*;
#(
  parameter int TARI_TICKS  = TARI_DEF,
  parameter int DATA1_TICKS = DATA1_DEF,
  parameter int PW_TICKS    = PW_DEF,
  parameter int DELIM_TICKS = DELIM_DEF,
  parameter int TRCAL_TICKS = TRCAL_DEF,
  parameter int LEN_W       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             with_trcal,
  input  logic [LEN_W-1:0] nbits,
  pie_tx_encoder_if.slave  cmd,
  output logic             tx_env,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int RTCAL_TICKS = TARI_TICKS + DATA1_TICKS;
  localparam int CNT_W = $clog2(max5(
    TARI_TICKS, DATA1_TICKS, DELIM_TICKS,
    TRCAL_TICKS, RTCAL_TICKS) + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t           state;
  logic             trcal_q;
  logic [LEN_W-1:0] left;

  logic t_load;
  cnt_t t_len;
  cnt_t t_pw;
  logic t_last;

  logic edge_end;
  logic at_bound;
  logic need_bit;
  logic pop;

  assign busy     = (state != IDLE);
  assign edge_end = tick && t_last && busy;
  assign at_bound = edge_end
                 && ((state == RTCAL && !trcal_q)
                  || state == TRCAL
                  || state == BITS);
  assign need_bit = at_bound && (left != '0);
  assign pop      = need_bit && cmd.in_vld;

  assign cmd.in_rdy = need_bit;

  // returning to idle loads a zero-length count with pw 0,
  // which holds the envelope at carrier-on
  always_comb begin
    t_load = 1'b0;
    t_len  = cnt_t'(1);
    t_pw   = '0;
    unique case (1'b1)
      (state == IDLE && start): begin
        t_load = 1'b1;
        t_len  = cnt_t'(DELIM_TICKS);
        t_pw   = cnt_t'(DELIM_TICKS);
      end
      (edge_end && state == DELIM): begin
        t_load = 1'b1;
        t_len  = cnt_t'(TARI_TICKS);
        t_pw   = cnt_t'(PW_TICKS);
      end
      (edge_end && state == DATA0): begin
        t_load = 1'b1;
        t_len  = cnt_t'(RTCAL_TICKS);
        t_pw   = cnt_t'(PW_TICKS);
      end
      (edge_end && state == RTCAL
        && trcal_q): begin
        t_load = 1'b1;
        t_len  = cnt_t'(TRCAL_TICKS);
        t_pw   = cnt_t'(PW_TICKS);
      end
      pop: begin
        t_load = 1'b1;
        t_len  = cmd.in_dat
               ? cnt_t'(DATA1_TICKS)
               : cnt_t'(TARI_TICKS);
        t_pw   = cnt_t'(PW_TICKS);
      end
      (at_bound && !pop): begin
        t_load = 1'b1;
      end
      default: ;
    endcase
  end

  pie_symbol_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .load   (t_load),
    .length (t_len),
    .pw     (t_pw),
    .env    (tx_env),
    .last   (t_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      trcal_q  <= 1'b0;
      left     <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            trcal_q <= with_trcal;
            left    <= nbits;
            state   <= DELIM;
          end
        end
        DELIM: begin
          if (edge_end) state <= DATA0;
        end
        DATA0: begin
          if (edge_end) state <= RTCAL;
        end
        RTCAL, TRCAL, BITS: begin
          if (edge_end) begin
            if (state == RTCAL && trcal_q) begin
              state <= TRCAL;
            end else if (left == '0) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (cmd.in_vld) begin
              left  <= left - LEN_W'(1);
              state <= BITS;
            end else begin
              underrun <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pie_tx_encoder.sv
// Directed bench for pie_tx_encoder: tick-sampled envelope,
// handshake counts, done/underrun timing and reset.
module tb_pie_tx_encoder;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       with_trcal;
  logic [8:0] nbits;
  logic       tx_env;
  logic       busy;
  logic       done;
  logic       underrun;

  pie_tx_encoder_if cmd ();

  pie_tx_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start      (start),
    .with_trcal (with_trcal),
    .nbits      (nbits),
    .cmd        (cmd),
    .tx_env     (tx_env),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [63:0] wave;
  int nticks;
  int pops;
  int done_cyc;
  int done_tick;
  int done_cnt;
  int und_cyc;
  int und_tick;
  logic post_ok;
  logic finished;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic run_frame(
    input logic       trc,
    input logic [8:0] nb,
    input logic [7:0] cb,
    input int         nvld,
    input int         per,
    input int         busy_cyc,
    input logic [8:0] nb2
  );
    int idx;
    int stop_at;
    idx = 0;
    stop_at = -1;
    wave = '0;
    nticks = 0;
    pops = 0;
    done_cyc = -1;
    done_tick = -1;
    done_cnt = 0;
    und_cyc = -1;
    und_tick = -1;
    post_ok = 1'b1;
    finished = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      tick = (cyc % per == 0);
      start = (cyc == 0) || (cyc == busy_cyc);
      with_trcal = (cyc == 0) ? trc : ~trc;
      nbits = (cyc == 0) ? nb : nb2;
      cmd.in_vld = (idx < nvld);
      cmd.in_dat = (idx < 8) ? cb[3'(7 - idx)] : 1'b0;
      #1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          done_tick = nticks;
        end
      end
      if (underrun && und_cyc < 0) begin
        und_cyc = cyc;
        und_tick = nticks;
      end
      if (stop_at >= 0 && (busy || !tx_env))
        post_ok = 1'b0;
      if (busy && tick) begin
        wave = {wave[62:0], tx_env};
        nticks++;
      end
      if (cmd.in_rdy && cmd.in_vld) begin
        pops++;
        idx++;
      end
      if (stop_at < 0 && (done_cyc >= 0 || und_cyc >= 0))
        stop_at = cyc + 4;
      if (cyc == stop_at) begin
        finished = 1'b1;
        break;
      end
    end
    tick = 1'b1;
    start = 1'b0;
    cmd.in_vld = 1'b0;
    chk("frame_end_in_time", 64'(finished), 64'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    tick = 1'b0;
    start = 1'b0;
    with_trcal = 1'b0;
    nbits = '0;
    cmd.in_dat = 1'b0;
    cmd.in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", 64'(tx_env), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_und", 64'(underrun), 64'd0);
    chk("rst_rdy", 64'(cmd.in_rdy), 64'd0);
    rst_n = 1'b1;

    // frame-sync, bits 1,0
    run_frame(1'b0, 9'd2, 8'b1000_0000, 8, 1, -1, 9'd2);
    chk("s1_nticks", 64'(nticks), 64'd27);
    chk("s1_wave", wave,
        64'(27'b000_1100_1111111100_111100_1100));
    chk("s1_pops", 64'(pops), 64'd2);
    chk("s1_done_tick", 64'(done_tick), 64'd27);
    chk("s1_done_cyc", 64'(done_cyc), 64'd28);
    chk("s1_done_cnt", 64'(done_cnt), 64'd1);
    chk("s1_idle_cw", 64'(post_ok), 64'd1);

    // preamble, bit 0
    run_frame(1'b1, 9'd1, 8'b0000_0000, 8, 1, -1, 9'd1);
    chk("s2_nticks", 64'(nticks), 64'd37);
    chk("s2_wave", wave,
        64'(37'b000_1100_1111111100_1111111111111100_1100));
    chk("s2_pops", 64'(pops), 64'd1);
    chk("s2_done_tick", 64'(done_tick), 64'd37);

    // tick every third cycle
    run_frame(1'b0, 9'd2, 8'b1000_0000, 8, 3, -1, 9'd2);
    chk("s3_nticks", 64'(nticks), 64'd27);
    chk("s3_wave", wave,
        64'(27'b000_1100_1111111100_111100_1100));
    chk("s3_done_cyc", 64'(done_cyc), 64'd82);
    chk("s3_done_tick", 64'(done_tick), 64'd27);

    // underrun before bit 2
    run_frame(1'b0, 9'd3, 8'b1010_0000, 2, 1, -1, 9'd3);
    chk("s4_pops", 64'(pops), 64'd2);
    chk("s4_und_tick", 64'(und_tick), 64'd27);
    chk("s4_und_cyc", 64'(und_cyc), 64'd28);
    chk("s4_done_cnt", 64'(done_cnt), 64'd0);
    chk("s4_idle_cw", 64'(post_ok), 64'd1);
    chk("s4_wave", wave,
        64'(27'b000_1100_1111111100_111100_1100));

    // reset during the RTcal low pulse
    @(posedge clk);
    #1;
    tick = 1'b1;
    start = 1'b1;
    nbits = 9'd2;
    with_trcal = 1'b0;
    cmd.in_vld = 1'b1;
    cmd.in_dat = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("s5_pre_env", 64'(tx_env), 64'd0);
    chk("s5_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_env", 64'(tx_env), 64'd1);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd.in_vld = 1'b0;
    run_frame(1'b0, 9'd2, 8'b1000_0000, 8, 1, -1, 9'd2);
    chk("s5_wave", wave,
        64'(27'b000_1100_1111111100_111100_1100));
    chk("s5_done_tick", 64'(done_tick), 64'd27);

    // start while busy with different nbits/with_trcal
    run_frame(1'b0, 9'd2, 8'b1000_0000, 8, 1, 5, 9'd5);
    chk("s6_nticks", 64'(nticks), 64'd27);
    chk("s6_wave", wave,
        64'(27'b000_1100_1111111100_111100_1100));
    chk("s6_pops", 64'(pops), 64'd2);
    chk("s6_done_cnt", 64'(done_cnt), 64'd1);

    // nbits = 0, frame-sync
    run_frame(1'b0, 9'd0, 8'b1111_1111, 8, 1, -1, 9'd0);
    chk("s6z_done_tick", 64'(done_tick), 64'd17);
    chk("s6z_wave", wave,
        64'(17'b000_1100_1111111100));
    chk("s6z_pops", 64'(pops), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
